agc_decode_stage: RTL and testbench

AGC_DECODE_STAGE -- requirements
Module: agc_decode_stage

---
 rtl/agc_decode_stage.sv | 153 +++++++++++++++
 tb/tb_agc_decode_stage.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_decode_stage.sv
// AGC decode stage: EXTEND/INDEX-aware instruction decoder with a
// valid/ready handshake on both sides and an absorbing HALT state.
module agc_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        idx_load,
  input  logic [14:0] idx_value,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [3:0]  dec_op,
  output logic [14:0] dec_word,
  output logic        dec_extended,
  output logic        halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [3:0] OP_TC    = 4'd0;
  localparam logic [3:0] OP_CCS   = 4'd1;
  localparam logic [3:0] OP_DV    = 4'd2;
  localparam logic [3:0] OP_CS    = 4'd3;
  localparam logic [3:0] OP_INDEX = 4'd4;
  localparam logic [3:0] OP_XCH   = 4'd5;
  localparam logic [3:0] OP_TS    = 4'd6;
  localparam logic [3:0] OP_AD    = 4'd7;
  localparam logic [3:0] OP_SU    = 4'd8;
  localparam logic [3:0] OP_MASK  = 4'd9;
  localparam logic [3:0] OP_MP    = 4'd10;
  localparam logic [3:0] OP_HALT  = 4'd12;
  localparam logic [3:0] OP_ILL   = 4'd15;

  localparam logic [14:0] W_EXTEND = 15'o00006;
  localparam logic [14:0] W_HALT   = 15'o77777;

  logic [1:0]  state_q, state_d;
  logic        ext_q, ext_d;
  logic        idxp_q, idxp_d;
  logic [14:0] idx_q, idx_d;
  logic [14:0] word_q, word_d;
  logic [3:0]  op_q, op_d;
  logic        extd_q, extd_d;

  logic [15:0] sum;
  logic [14:0] w_sum;
  logic [14:0] w;
  logic [3:0]  dop;

  assign instr_ready  = (state_q == S_IDLE);
  assign dec_valid    = (state_q == S_HOLD);
  assign halted       = (state_q == S_HALT);
  assign dec_op       = op_q;
  assign dec_word     = word_q;
  assign dec_extended = extd_q;

  // Ones'-complement add with end-around carry for INDEX modification
  always_comb begin
    sum   = {1'b0, instr_in} + {1'b0, idx_q};
    w_sum = sum[14:0] + {14'd0, sum[15]};
    w     = idxp_q ? w_sum : instr_in;
  end

  always_comb begin
    dop = OP_ILL;
    if (w == W_HALT) begin
      dop = OP_HALT;
    end else begin
      case (w[14:12])
        3'b000: dop = OP_TC;
        3'b001: dop = ext_q ? OP_DV : OP_CCS;
        3'b100: dop = OP_CS;
        3'b101: begin
          case (w[11:10])
            2'b00:   dop = OP_INDEX;
            2'b11:   dop = OP_XCH;
            2'b10:   dop = OP_TS;
            default: dop = OP_ILL;
          endcase
        end
        3'b110: dop = ext_q ? OP_SU : OP_AD;
        3'b111: dop = ext_q ? OP_MP : OP_MASK;
        default: dop = OP_ILL;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    idxp_d  = idxp_q;
    idx_d   = idx_q;
    word_d  = word_q;
    op_d    = op_q;
    extd_d  = extd_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (instr_in == W_EXTEND) begin
            ext_d = 1'b1;
          end else begin
            word_d  = w;
            op_d    = dop;
            extd_d  = ext_q;
            idxp_d  = 1'b0;
            ext_d   = (dop == OP_INDEX) ? ext_q : 1'b0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (dec_ready) begin
          if (op_q == OP_INDEX)     state_d = S_WAIT;
          else if (op_q == OP_HALT) state_d = S_HALT;
          else                      state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (idx_load) begin
          idx_d   = idx_value;
          idxp_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ext_q   <= 1'b0;
      idxp_q  <= 1'b0;
      idx_q   <= '0;
      word_q  <= '0;
      op_q    <= '0;
      extd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      idxp_q  <= idxp_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      op_q    <= op_d;
      extd_q  <= extd_d;
    end
  end

endmodule

// File: tb/tb_agc_decode_stage.sv
// Bench for agc_decode_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_agc_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        idx_load;
  logic [14:0] idx_value;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_op;
  logic [14:0] dec_word;
  logic        dec_extended;
  logic        halted;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  agc_decode_stage dut (
    .clk(clk), .reset(reset),
    .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .idx_load(idx_load), .idx_value(idx_value),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_op(dec_op), .dec_word(dec_word),
    .dec_extended(dec_extended), .halted(halted)
  );

  function automatic int m_add(input int a, input int b);
    int s;
    s = a + b;
    return (s > 32767) ? s - 32767 : s;
  endfunction

  function automatic int m_decode(input int w, input bit ext);
    int opc, qc;
    if (w == 32767) return 12;
    opc = w / 4096;
    qc = (w / 1024) % 4;
    case (opc)
      0: return 0;
      1: return ext ? 2 : 1;
      4: return 3;
      5: begin
        if (qc == 0) return 4;
        if (qc == 3) return 5;
        if (qc == 2) return 6;
        return 15;
      end
      6: return ext ? 8 : 7;
      7: return ext ? 10 : 9;
      default: return 15;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [14:0] w);
    instr_in = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    idx_load = 1'b0;
  endtask

  task automatic take();
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    instr_in = '0;
    idx_load = 1'b0;
    idx_value = '0;
    dec_ready = 1'b0;
    #2;
    total++;
    if ({instr_ready, dec_valid, halted} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=100",
               {instr_ready, dec_valid, halted});
    end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({dec_op, dec_word, dec_extended} !== 20'd0) begin
      bad++;
      $display("FAIL reset_regs op=%0d word=%o ext=%b want 0",
               dec_op, dec_word, dec_extended);
    end
  endtask

  task automatic test_ccs();
    push(15'o10100);
    total++;
    if ({dec_valid, instr_ready, dec_op, dec_word[9:0], dec_extended}
        !== {1'b1, 1'b0, 4'd1, 10'o0100, 1'b0}) begin
      bad++;
      $display("FAIL ccs v=%b op=%0d a10=%o ext=%b want v=1 op=1 a10=100",
               dec_valid, dec_op, dec_word[9:0], dec_extended);
    end
    take();
    total++;
    if ({dec_valid, instr_ready} !== 2'b01) begin
      bad++;
      $display("FAIL ccs_drop got=%b want=01", {dec_valid, instr_ready});
    end
  endtask

  task automatic test_extend();
    push(15'o00006);
    total++;
    if ({dec_valid, instr_ready} !== 2'b01) begin
      bad++;
      $display("FAIL ext_silent got=%b want=01", {dec_valid, instr_ready});
    end
    push(15'o00006);
    push(15'o10100);
    total++;
    if ({dec_valid, dec_op, dec_extended} !== {1'b1, 4'd2, 1'b1}) begin
      bad++;
      $display("FAIL ext_dv v=%b op=%0d ext=%b want 1 2 1",
               dec_valid, dec_op, dec_extended);
    end
    take();
    push(15'o10100);
    total++;
    if ({dec_valid, dec_op, dec_extended} !== {1'b1, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL ext_clear v=%b op=%0d ext=%b want 1 1 0",
               dec_valid, dec_op, dec_extended);
    end
    take();
  endtask

  task automatic test_index();
    push(15'o50100);
    total++;
    if (dec_op !== 4'd4) begin
      bad++;
      $display("FAIL idx_op got=%0d want=4", dec_op);
    end
    take();
    instr_in = 15'o10100;
    instr_valid = 1'b1;
    tick();
    tick();
    instr_valid = 1'b0;
    total++;
    if ({instr_ready, dec_valid} !== 2'b00) begin
      bad++;
      $display("FAIL idx_wait got=%b want=00", {instr_ready, dec_valid});
    end
    idx_load = 1'b1;
    idx_value = 15'o00002;
    tick();
    idx_load = 1'b0;
    push(15'o60200);
    total++;
    if ({dec_op, dec_word} !== {4'd7, 15'o60202}) begin
      bad++;
      $display("FAIL idx_ad op=%0d word=%o want op=7 word=60202",
               dec_op, dec_word);
    end
    take();
    push(15'o50100);
    take();
    idx_load = 1'b1;
    idx_value = 15'o77777;
    tick();
    idx_load = 1'b0;
    push(15'o00001);
    total++;
    if ({dec_op, dec_word} !== {4'd0, 15'o00001}) begin
      bad++;
      $display("FAIL idx_eac op=%0d word=%o want op=0 word=00001",
               dec_op, dec_word);
    end
    take();
  endtask

  task automatic test_hold_halt();
    push(15'o40123);
    for (int k = 0; k < 5; k++) begin
      instr_valid = 1'b1;
      instr_in = 15'o77777;
      tick();
      total++;
      if ({dec_valid, instr_ready, dec_op, dec_word}
          !== {1'b1, 1'b0, 4'd3, 15'o40123}) begin
        bad++;
        $display("FAIL hold_stable k=%0d v=%b r=%b op=%0d w=%o",
                 k, dec_valid, instr_ready, dec_op, dec_word);
      end
    end
    instr_valid = 1'b0;
    take();
    push(15'o77777);
    total++;
    if (dec_op !== 4'd12) begin
      bad++;
      $display("FAIL halt_op got=%0d want=12", dec_op);
    end
    take();
    total++;
    if ({halted, instr_ready, dec_valid} !== 3'b100) begin
      bad++;
      $display("FAIL halt_state got=%b want=100",
               {halted, instr_ready, dec_valid});
    end
    instr_valid = 1'b1;
    instr_in = 15'o10100;
    dec_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    instr_valid = 1'b0;
    dec_ready = 1'b0;
    total++;
    if ({halted, instr_ready, dec_valid} !== 3'b100) begin
      bad++;
      $display("FAIL halt_absorb got=%b want=100",
               {halted, instr_ready, dec_valid});
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    push(15'o00006);
    push(15'o10100);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if ({dec_valid, instr_ready} !== 2'b01) begin
      bad++;
      $display("FAIL rst_mid got=%b want=01", {dec_valid, instr_ready});
    end
    tick();
    reset = 1'b0;
    push(15'o60200);
    total++;
    if ({dec_valid, dec_op, dec_word, dec_extended}
        !== {1'b1, 4'd7, 15'o60200, 1'b0}) begin
      bad++;
      $display("FAIL rst_ad v=%b op=%0d w=%o ext=%b want 1 7 60200 0",
               dec_valid, dec_op, dec_word, dec_extended);
    end
    take();
  endtask

  task automatic test_random();
    bit m_ext, m_idxp, ext_exp;
    int m_idx, w, op, r, holds, v;
    logic [14:0] word;
    do_reset();
    m_ext = 0;
    m_idxp = 0;
    m_idx = 0;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 15);
      if (r < 4) word = 15'o00006;
      else if (r == 4) word = 15'o77777;
      else word = 15'($urandom);
      idx_load = 1'($urandom);
      idx_value = 15'($urandom);
      push(word);
      if (word == 15'o00006) begin
        m_ext = 1;
        total++;
        if ({dec_valid, instr_ready} !== 2'b01) begin
          bad++;
          $display("FAIL rnd_ext it=%0d got=%b want=01",
                   it, {dec_valid, instr_ready});
        end
        continue;
      end
      w = m_idxp ? m_add(int'(word), m_idx) : int'(word);
      op = m_decode(w, m_ext);
      ext_exp = m_ext;
      m_idxp = 0;
      if (op != 4) m_ext = 0;
      holds = $urandom_range(0, 3);
      for (int k = 0; k <= holds; k++) begin
        total++;
        if ({dec_valid, instr_ready, dec_op, dec_word, dec_extended}
            !== {1'b1, 1'b0, 4'(op), 15'(w), ext_exp}) begin
          bad++;
          $display("FAIL rnd_dec it=%0d v=%b op=%0d w=%o x=%b want op=%0d w=%o x=%b",
                   it, dec_valid, dec_op, dec_word, dec_extended,
                   op, w, ext_exp);
        end
        if (k < holds) begin
          instr_valid = 1'($urandom);
          instr_in = 15'($urandom);
          idx_load = 1'($urandom);
          tick();
        end
      end
      instr_valid = 1'b0;
      idx_load = 1'b0;
      take();
      if (op == 4) begin
        v = $urandom_range(0, 3) == 0 ? 32767 : int'($urandom_range(0, 32767));
        instr_valid = 1'b1;
        instr_in = 15'($urandom);
        for (int k = $urandom_range(0, 2); k > 0; k--) tick();
        total++;
        if ({instr_ready, dec_valid} !== 2'b00) begin
          bad++;
          $display("FAIL rnd_wait it=%0d got=%b want=00",
                   it, {instr_ready, dec_valid});
        end
        idx_load = 1'b1;
        idx_value = 15'(v);
        tick();
        idx_load = 1'b0;
        instr_valid = 1'b0;
        m_idx = v;
        m_idxp = 1;
      end
      if (op == 12) begin
        total++;
        if ({halted, instr_ready, dec_valid} !== 3'b100) begin
          bad++;
          $display("FAIL rnd_halt it=%0d got=%b want=100",
                   it, {halted, instr_ready, dec_valid});
        end
        do_reset();
        m_ext = 0;
        m_idxp = 0;
        m_idx = 0;
      end else begin
        total++;
        if ({instr_ready, dec_valid, halted} !== 3'b100) begin
          bad++;
          $display("FAIL rnd_idle it=%0d got=%b want=100",
                   it, {instr_ready, dec_valid, halted});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ccs();
    test_extend();
    test_index();
    test_hold_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
